// File: rtl/kernel_pkg.sv
// Shared kernel geometry: a 3x3 window of 8-bit taps packed into 9 byte lanes,
// used by the FIFO unpacker and the input-layer window logic.
package kernel_pkg;

  localparam int BYTE_WIDTH   = 8;
  localparam int KERNEL_ROWS  = 3;
  localparam int KERNEL_COLS  = 3;
  localparam int KERNEL_BYTES = KERNEL_ROWS * KERNEL_COLS;

  // Byte lane of each window tap; row-major, lane n is kernel bits [8n+7:8n].
  localparam int LANE_R0C0 = 0;
  localparam int LANE_R0C1 = 1;
  localparam int LANE_R0C2 = 2;
  localparam int LANE_R1C0 = 3;
  localparam int LANE_R1C1 = 4;
  localparam int LANE_R1C2 = 5;
  localparam int LANE_R2C0 = 6;
  localparam int LANE_R2C1 = 7;
  localparam int LANE_R2C2 = 8;

  function automatic int win_lane(input int row, input int col);
    return row * KERNEL_COLS + col;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with occupancy count; a write into a full FIFO is
// still accepted when a pop frees the head slot in the same cycle.
module sync_fifo_sa #(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 64,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   drop
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   do_push, do_pop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = rd_en && (count_q != '0);
    do_push  = wr_en && ((count_q != FULL_COUNT) || do_pop);
    drop     = wr_en && !do_push;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (reset_n && !clear && do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/kernel_fifo_unpacker.sv
// Buffers 64-bit kernel words from the loader and repacks the byte stream into
// 72-bit 3x3 kernels presented on a valid/ready interface.
module kernel_fifo_unpacker
  import kernel_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int KERNEL_WIDTH = 72,
  parameter int DEPTH        = 64,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  output logic [COUNT_WIDTH-1:0]  fifo_count,
  output logic                    overflow_o,
  output logic [KERNEL_WIDTH-1:0] kernel_o,
  output logic                    kernel_valid_o,
  input  logic                    kernel_rdy_i
);

  localparam int IN_BYTES  = DATA_WIDTH / BYTE_WIDTH;
  localparam int RES_BYTES = 2 * IN_BYTES;
  localparam int RES_WIDTH = 2 * DATA_WIDTH;
  localparam int RB_WIDTH  = $clog2(RES_BYTES + 1);
  localparam logic [RB_WIDTH-1:0] KB = RB_WIDTH'(KERNEL_BYTES);
  localparam logic [RB_WIDTH-1:0] IB = RB_WIDTH'(IN_BYTES);

  logic [DATA_WIDTH-1:0]   head;
  logic                    fifo_empty, fifo_drop;
  logic                    load, pop;
  logic [RES_WIDTH-1:0]    res_q, res_d, res_a;
  logic [RB_WIDTH-1:0]     rb_q, rb_d, rb_a;
  logic [KERNEL_WIDTH-1:0] kernel_q, kernel_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;

  sync_fifo_sa #(
    .WIDTH       (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .drop    (fifo_drop)
  );

  // Bytes at and above rb are always zero, so a popped word is simply OR-ed in at rb_a.
  always_comb begin
    load       = (rb_q >= KB) && (!valid_q || kernel_rdy_i);
    rb_a       = load ? (rb_q - KB) : rb_q;
    res_a      = load ? (res_q >> KERNEL_WIDTH) : res_q;
    pop        = !fifo_empty && (rb_a < KB);
    rb_d       = pop ? (rb_a + IB) : rb_a;
    res_d      = pop ? (res_a | (RES_WIDTH'(head) << {rb_a, 3'b000})) : res_a;
    kernel_d   = load ? res_q[KERNEL_WIDTH-1:0] : kernel_q;
    overflow_d = overflow_q || fifo_drop;
    valid_d    = valid_q;
    if (load)              valid_d = 1'b1;
    else if (kernel_rdy_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      res_q      <= '0;
      rb_q       <= '0;
      kernel_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      res_q      <= res_d;
      rb_q       <= rb_d;
      kernel_q   <= kernel_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign kernel_o       = kernel_q;
  assign kernel_valid_o = valid_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_kernel_fifo_unpacker.sv
// Self-checking bench for kernel_fifo_unpacker: a byte-queue model of the stream
// checks every transferred kernel, plus directed latency/backpressure/clear cases.
module tb_kernel_fifo_unpacker;

  localparam int DW    = 64;
  localparam int KW    = 72;
  localparam int DEPTH = 64;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [CW-1:0] fifo_count;
  logic          overflow_o;
  logic [KW-1:0] kernel_o;
  logic          kernel_valid_o;
  logic          kernel_rdy_i;

  always #5 clk = ~clk;

  kernel_fifo_unpacker #(
    .DATA_WIDTH   (DW),
    .KERNEL_WIDTH (KW),
    .DEPTH        (DEPTH),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .fifo_count     (fifo_count),
    .overflow_o     (overflow_o),
    .kernel_o       (kernel_o),
    .kernel_valid_o (kernel_valid_o),
    .kernel_rdy_i   (kernel_rdy_i)
  );

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    logic          rdy;
    logic [CW-1:0] cnt;
    logic          vld;
    logic          chk_k;
    logic [KW-1:0] k;
  } vec_t;

  localparam logic [KW-1:0] K_FIRST = 72'h080706050403020100;
  localparam logic [KW-1:0] K_LAST  = 72'h4746454443424140_3F;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_xfer   = 0;
  byte unsigned  exp_q[$];
  logic [KW-1:0] first_xfer;
  logic [KW-1:0] last_xfer;
  vec_t          lat_tab[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramp_word(input int base);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 8; i++) w[8*i +: 8] = 8'(base + i);
    return w;
  endfunction

  task automatic push_model(input logic [DW-1:0] w);
    for (int i = 0; i < DW / 8; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Scoreboards any handshake in the current cycle, then advances one edge.
  task automatic tick();
    logic [KW-1:0] exp_k;
    if (reset_n && !clear && kernel_valid_o && kernel_rdy_i) begin
      if (exp_q.size() < 9) begin
        n_checks++;
        n_fail++;
        $display("FAIL kernel_extra: got 0x%0h, want no kernel", kernel_o);
      end else begin
        for (int i = 0; i < 9; i++) exp_k[8*i +: 8] = exp_q.pop_front();
        check("kernel_stream", kernel_o, exp_k);
      end
      if (n_xfer == 0) first_xfer = kernel_o;
      last_xfer = kernel_o;
      n_xfer++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [DW-1:0] d, input logic rdy);
    wr_en        = we;
    wr_data      = d;
    kernel_rdy_i = rdy;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear   = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    n_xfer = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          we;
    logic [DW-1:0] d;
    int            sent;
    int            cyc;

    reset_n = 1'b0;
    clear   = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Latency from an empty block: writes at edges 0 and 1, kernel valid after edge 3.
    lat_tab[0] = '{we: 1'b1, data: ramp_word(0), rdy: 1'b1, cnt: 8'd1, vld: 1'b0, chk_k: 1'b0, k: '0};
    lat_tab[1] = '{we: 1'b1, data: ramp_word(8), rdy: 1'b1, cnt: 8'd1, vld: 1'b0, chk_k: 1'b0, k: '0};
    lat_tab[2] = '{we: 1'b0, data: '0,           rdy: 1'b1, cnt: 8'd0, vld: 1'b0, chk_k: 1'b0, k: '0};
    lat_tab[3] = '{we: 1'b0, data: '0,           rdy: 1'b1, cnt: 8'd0, vld: 1'b1, chk_k: 1'b1, k: K_FIRST};
    lat_tab[4] = '{we: 1'b0, data: '0,           rdy: 1'b1, cnt: 8'd0, vld: 1'b0, chk_k: 1'b0, k: '0};

    do_reset();
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_valid", kernel_valid_o, 0);
    check("rst_kernel", kernel_o, 0);

    for (int i = 0; i < 5; i++) begin
      drive(lat_tab[i].we, lat_tab[i].data, lat_tab[i].rdy);
      if (lat_tab[i].we) push_model(lat_tab[i].data);
      tick();
      check($sformatf("lat%0d_count", i), fifo_count, lat_tab[i].cnt);
      check($sformatf("lat%0d_valid", i), kernel_valid_o, lat_tab[i].vld);
      if (lat_tab[i].chk_k) check($sformatf("lat%0d_kernel", i), kernel_o, lat_tab[i].k);
    end

    // Nine ramp words produce exactly eight kernels and drain the gearbox.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, ramp_word(8 * i), 1'b1);
      push_model(ramp_word(8 * i));
      tick();
    end
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 30; c++) tick();
    check("nine_kernels", n_xfer, 8);
    check("nine_first", first_xfer, K_FIRST);
    check("nine_last", last_xfer, K_LAST);
    check("nine_count", fifo_count, 0);
    check("nine_valid", kernel_valid_o, 0);

    // Backpressure: gearbox absorbs 3 words, FIFO fills, 68th write dropped.
    do_reset();
    for (int i = 0; i < 68; i++) begin
      drive(1'b1, ramp_word(8 * i), 1'b0);
      if (i < 67) push_model(ramp_word(8 * i));
      tick();
      if (kernel_valid_o) check("bp_hold", kernel_o, K_FIRST);
      if (i == 66) begin
        check("bp_count67", fifo_count, 64);
        check("bp_ovf67", overflow_o, 0);
      end
      if (i == 67) begin
        check("bp_count68", fifo_count, 64);
        check("bp_ovf68", overflow_o, 1);
      end
    end
    check("bp_valid", kernel_valid_o, 1);
    check("bp_no_xfer", n_xfer, 0);
    clear = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    clear = 1'b0;
    exp_q.delete();
    check("clr_full_count", fifo_count, 0);
    check("clr_full_ovf", overflow_o, 0);
    check("clr_full_valid", kernel_valid_o, 0);

    // Full FIFO with a same-cycle write and pop: write accepted, no overflow.
    do_reset();
    for (int i = 0; i < 67; i++) begin
      drive(1'b1, ramp_word(8 * i), 1'b0);
      push_model(ramp_word(8 * i));
      tick();
    end
    check("fp_pre_count", fifo_count, 64);
    drive(1'b1, ramp_word(8 * 67), 1'b1);
    push_model(ramp_word(8 * 67));
    tick();
    check("fp_count", fifo_count, 64);
    check("fp_ovf", overflow_o, 0);
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 200; c++) tick();
    check("fp_drain_kernels", n_xfer, 60);
    check("fp_drain_count", fifo_count, 0);
    check("fp_drain_ovf", overflow_o, 0);

    // Clear mid-stream with a partial residue and five queued words.
    do_reset();
    drive(1'b1, ramp_word(8'hA0), 1'b1);
    push_model(ramp_word(8'hA0));
    tick();
    drive(1'b1, ramp_word(8'hA8), 1'b1);
    push_model(ramp_word(8'hA8));
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    check("mid_valid", kernel_valid_o, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ramp_word(8'hB0 + 8 * i), 1'b0);
      push_model(ramp_word(8'hB0 + 8 * i));
      tick();
    end
    check("mid_count", fifo_count, 5);
    clear = 1'b1;
    drive(1'b1, ramp_word(8'hF0), 1'b1);
    tick();
    clear = 1'b0;
    exp_q.delete();
    n_xfer = 0;
    check("clr_count", fifo_count, 0);
    check("clr_valid", kernel_valid_o, 0);
    check("clr_kernel", kernel_o, 0);
    check("clr_ovf", overflow_o, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, ramp_word(8 * i), 1'b1);
      push_model(ramp_word(8 * i));
      tick();
    end
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 30; c++) tick();
    check("clr_reload_first", first_xfer, K_FIRST);
    check("clr_reload_kernels", n_xfer, 8);

    // Random traffic: writer throttles on fifo_count, consumer ready ~1/8 of cycles.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (n_xfer < 80 && cyc < 4000) begin
      we = (sent < 90) && ($urandom_range(0, 3) != 0) && (fifo_count < CW'(DEPTH));
      d  = {$urandom(), $urandom()};
      drive(we, d, $urandom_range(0, 7) == 0);
      if (we) begin
        push_model(d);
        sent++;
      end
      tick();
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    check("rnd_kernels", n_xfer, 80);
    check("rnd_ovf", overflow_o, 0);
    check("rnd_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
